// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register of the 5-stage MIPS core:
// the width of the decoded control word, the bit position of each control
// field inside it, and the ALUOp encodings driven by the decode unit.
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int CTRL_W = 10;

    // Control-word bit positions
    localparam int CTRL_ALUOP_HI = 9;
    localparam int CTRL_ALUOP_LO = 8;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_JUMP     = 0;

    // ALUOp encodings
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_OR    = 2'b10,
        ALUOP_RTYPE = 2'b11
    } aluop_e;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// -----------------------------------------------------------------------------
// id_ex_hazard
// Combinational load-use comparator. Flags a hazard when the instruction in
// EX is a valid load whose destination (rt) is a source the ID instruction
// actually reads. Register $0 never creates a hazard.
//
// Ports:
//   ctrl_i        decoded control word of the ID instruction
//   rs_addr_i     ID rs field
//   rt_addr_i     ID rt field
//   ex_valid_i    EX slot holds a real instruction
//   ex_memread_i  EX instruction is a load
//   ex_rt_addr_i  EX instruction's rt (load destination)
//   hazard_o      load-use hazard detected
// -----------------------------------------------------------------------------
module id_ex_hazard
    import id_ex_stage_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [AW-1:0]     rs_addr_i,
    input  logic [AW-1:0]     rt_addr_i,
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [AW-1:0]     ex_rt_addr_i,
    output logic              hazard_o
);

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_rs_match;
    logic w_rt_match;

    // Every real instruction except a jump reads rs; only R-type, sw and beq read rt.
    assign w_uses_rs  = ~ctrl_i[CTRL_JUMP] & (ctrl_i != '0);
    assign w_uses_rt  = ctrl_i[CTRL_REGDST] | ctrl_i[CTRL_MEMWRITE] | ctrl_i[CTRL_BRANCH];
    assign w_rs_match = w_uses_rs & (rs_addr_i == ex_rt_addr_i);
    assign w_rt_match = w_uses_rt & (rt_addr_i == ex_rt_addr_i);

    assign hazard_o = ex_valid_i & ex_memread_i & (ex_rt_addr_i != '0)
                    & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall and branch/jump flush.
// Each edge either captures the ID instruction or loads a bubble (all zeros)
// when flushed or when a load-use hazard is detected. A bubble removes the
// load from EX, so a stall lasts exactly one cycle.
//
// Optional feature macro: ID_EX_PERF_EN
//   adds bubble_cnt_o, a saturating count of bubbles loaded.
//
// Ports:
//   clk_i, rst_i                          clock, async active-high reset
//   ctrl_i / ctrl_o                       decoded control word in / to EX
//   pc4_i, rs_data_i, rt_data_i, imm_i    operands in; *_o registered
//   rs_addr_i, rt_addr_i, rd_addr_i       register fields in; *_o registered
//   flush_i                               kill the ID instruction
//   valid_o                               EX slot holds a real instruction
//   stall_o                               hold PC and IF/ID this cycle
//   bubble_cnt_o                          (ID_EX_PERF_EN only) bubble count
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DW-1:0]     pc4_i,
    input  logic [DW-1:0]     rs_data_i,
    input  logic [DW-1:0]     rt_data_i,
    input  logic [DW-1:0]     imm_i,
    input  logic [AW-1:0]     rs_addr_i,
    input  logic [AW-1:0]     rt_addr_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DW-1:0]     pc4_o,
    output logic [DW-1:0]     rs_data_o,
    output logic [DW-1:0]     rt_data_o,
    output logic [DW-1:0]     imm_o,
    output logic [AW-1:0]     rs_addr_o,
    output logic [AW-1:0]     rt_addr_o,
    output logic [AW-1:0]     rd_addr_o,
    output logic              valid_o,
    output logic              stall_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       bubble_cnt_o
`endif
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DW-1:0]     r_pc4;
    logic [DW-1:0]     r_rs_data;
    logic [DW-1:0]     r_rt_data;
    logic [DW-1:0]     r_imm;
    logic [AW-1:0]     r_rs_addr;
    logic [AW-1:0]     r_rt_addr;
    logic [AW-1:0]     r_rd_addr;
    logic              r_valid;

    logic w_hazard;
    logic w_bubble;

    id_ex_hazard #(.AW(AW)) u_hazard (
        .ctrl_i       (ctrl_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .ex_valid_i   (r_valid),
        .ex_memread_i (r_ctrl[CTRL_MEMREAD]),
        .ex_rt_addr_i (r_rt_addr),
        .hazard_o     (w_hazard)
    );

    // Flush and hazard both load the same all-zero bubble; flush only masks
    // the stall request so the killed instruction is not held.
    assign w_bubble = flush_i | w_hazard;
    assign stall_o  = w_hazard & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl    <= '0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
        end else if (w_bubble) begin
            r_ctrl    <= '0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_ctrl    <= ctrl_i;
            r_pc4     <= pc4_i;
            r_rs_data <= rs_data_i;
            r_rt_data <= rt_data_i;
            r_imm     <= imm_i;
            r_rs_addr <= rs_addr_i;
            r_rt_addr <= rt_addr_i;
            r_rd_addr <= rd_addr_i;
            r_valid   <= (ctrl_i != '0);
        end
    end

    assign ctrl_o    = r_ctrl;
    assign pc4_o     = r_pc4;
    assign rs_data_o = r_rs_data;
    assign rt_data_o = r_rt_data;
    assign imm_o     = r_imm;
    assign rs_addr_o = r_rs_addr;
    assign rt_addr_o = r_rt_addr;
    assign rd_addr_o = r_rd_addr;
    assign valid_o   = r_valid;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage: each driven instruction pushes its expected
// EX-slot contents; the entry is popped and compared one edge later.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [9:0] C_ADDI = 10'h050;
    localparam logic [9:0] C_LW   = 10'h074;
    localparam logic [9:0] C_ADD  = 10'h390;
    localparam logic [9:0] C_SW   = 10'h048;
    localparam logic [9:0] C_J    = 10'h001;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [9:0]    ctrl_i;
    logic [DW-1:0] pc4_i, rs_data_i, rt_data_i, imm_i;
    logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
    logic          flush_i;
    logic [9:0]    ctrl_o;
    logic [DW-1:0] pc4_o, rs_data_o, rt_data_o, imm_o;
    logic [AW-1:0] rs_addr_o, rt_addr_o, rd_addr_o;
    logic          valid_o;
    logic          stall_o;
`ifdef ID_EX_PERF_EN
    logic [31:0]   bubble_cnt_o;
    int unsigned   exp_cnt = 0;
`endif

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.DW(DW), .AW(AW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ctrl_i    (ctrl_i),
        .pc4_i     (pc4_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .imm_i     (imm_i),
        .rs_addr_i (rs_addr_i),
        .rt_addr_i (rt_addr_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .ctrl_o    (ctrl_o),
        .pc4_o     (pc4_o),
        .rs_data_o (rs_data_o),
        .rt_data_o (rt_data_o),
        .imm_o     (imm_o),
        .rs_addr_o (rs_addr_o),
        .rt_addr_o (rt_addr_o),
        .rd_addr_o (rd_addr_o),
        .valid_o   (valid_o),
        .stall_o   (stall_o)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    typedef struct packed {
        logic [9:0]    ctrl;
        logic          valid;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] imm;
        logic [AW-1:0] rsa;
        logic [AW-1:0] rta;
        logic [AW-1:0] rda;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   seq   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".ctrl"},  64'(ctrl_o), 64'd0);
        chk({tag, ".valid"}, 64'(valid_o), 64'd0);
        chk({tag, ".data"},  64'(pc4_o | rs_data_o | rt_data_o | imm_o), 64'd0);
        chk({tag, ".addr"},  64'(rs_addr_o | rt_addr_o | rd_addr_o), 64'd0);
        chk({tag, ".stall"}, 64'(stall_o), 64'd0);
    endtask

    // Called at a negedge: drive one ID instruction, check the stall request,
    // record the expected EX contents, then check them after the next edge.
    task automatic step(input string tag, input logic [9:0] c,
                        input logic [AW-1:0] rsa, input logic [AW-1:0] rta,
                        input logic [AW-1:0] rda, input logic [DW-1:0] imm,
                        input logic fl, input logic exp_stall);
        exp_t e;
        exp_t g;
        seq++;
        ctrl_i    = c;
        rs_addr_i = rsa;
        rt_addr_i = rta;
        rd_addr_i = rda;
        imm_i     = imm;
        pc4_i     = 32'h0040_0000 + 32'(seq * 4);
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        flush_i   = fl;
        #1;
        chk({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
        if (fl || exp_stall) begin
            e = '0;
        end else begin
            e.ctrl  = c;
            e.valid = (c != 10'd0);
            e.pc4   = pc4_i;
            e.rsd   = rs_data_i;
            e.rtd   = rt_data_i;
            e.imm   = imm;
            e.rsa   = rsa;
            e.rta   = rta;
            e.rda   = rda;
        end
        q.push_back(e);
`ifdef ID_EX_PERF_EN
        if (fl || exp_stall) exp_cnt++;
`endif
        @(posedge clk_i);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            g = q.pop_front();
            chk({tag, ".ctrl"},   64'(ctrl_o),    64'(g.ctrl));
            chk({tag, ".valid"},  64'(valid_o),   64'(g.valid));
            chk({tag, ".pc4"},    64'(pc4_o),     64'(g.pc4));
            chk({tag, ".rsdata"}, 64'(rs_data_o), 64'(g.rsd));
            chk({tag, ".rtdata"}, 64'(rt_data_o), 64'(g.rtd));
            chk({tag, ".imm"},    64'(imm_o),     64'(g.imm));
            chk({tag, ".addr"},   64'({rs_addr_o, rt_addr_o, rd_addr_o}),
                                  64'({g.rsa, g.rta, g.rda}));
        end
`ifdef ID_EX_PERF_EN
        chk({tag, ".bcnt"}, 64'(bubble_cnt_o), 64'(exp_cnt));
`endif
        @(negedge clk_i);
    endtask

    initial begin
        // Reset held with nonzero inputs present.
        rst_i     = 1'b1;
        ctrl_i    = C_LW;
        pc4_i     = 32'hDEAD_BEEF;
        rs_data_i = 32'h1111_1111;
        rt_data_i = 32'h2222_2222;
        imm_i     = 32'h3333_3333;
        rs_addr_i = 5'd8;
        rt_addr_i = 5'd8;
        rd_addr_i = 5'd9;
        flush_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Pass-through addi
        step("addi",      C_ADDI, 5'd3, 5'd4, 5'd0, 32'h5, 1'b0, 1'b0);
        // Load-use on rs: lw rt=8, add rs=8 -> one stall, then add captured
        step("lw8",       C_LW,   5'd1, 5'd8, 5'd0, 32'h10, 1'b0, 1'b0);
        step("add_stall", C_ADD,  5'd8, 5'd9, 5'd10, 32'h20, 1'b0, 1'b1);
        step("add_retry", C_ADD,  5'd8, 5'd9, 5'd10, 32'h20, 1'b0, 1'b0);
        // $0 never a hazard source
        step("lw0",       C_LW,   5'd1, 5'd0, 5'd0, 32'h4, 1'b0, 1'b0);
        step("add_r0",    C_ADD,  5'd0, 5'd0, 5'd11, 32'h0, 1'b0, 1'b0);
        // addi does not read rt
        step("lw8b",      C_LW,   5'd2, 5'd8, 5'd0, 32'h8, 1'b0, 1'b0);
        step("addi_rt8",  C_ADDI, 5'd4, 5'd8, 5'd0, 32'h7, 1'b0, 1'b0);
        // Flush beats hazard
        step("lw8c",      C_LW,   5'd2, 5'd8, 5'd0, 32'hC, 1'b0, 1'b0);
        step("add_flush", C_ADD,  5'd8, 5'd9, 5'd12, 32'h0, 1'b1, 1'b0);
        // Flushed jump
        step("j_flush",   C_J,    5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0);
        // Load-use on rt via sw
        step("lw5",       C_LW,   5'd3, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0);
        step("sw_stall",  C_SW,   5'd2, 5'd5, 5'd0, 32'h18, 1'b0, 1'b1);
        step("sw_retry",  C_SW,   5'd2, 5'd5, 5'd0, 32'h18, 1'b0, 1'b0);
        // Jump reads no register: no stall even when rs field matches
        step("lw6",       C_LW,   5'd3, 5'd6, 5'd0, 32'h0, 1'b0, 1'b0);
        step("j_nostall", C_J,    5'd6, 5'd6, 5'd0, 32'h3FF, 1'b0, 1'b0);
        // Unflushed jump then zero control word (valid_o stays 0)
        step("nop",       10'd0,  5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);

        // Reset asserted mid-stall clears outputs without an edge.
        step("lw7",       C_LW,   5'd1, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0);
        ctrl_i    = C_ADD;
        rs_addr_i = 5'd7;
        rt_addr_i = 5'd9;
        #1;
        chk("midrst.pre_stall", 64'(stall_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk_outputs_zero("midrst");
`ifdef ID_EX_PERF_EN
        chk("midrst.bcnt", 64'(bubble_cnt_o), 64'd0);
        exp_cnt = 0;
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        step("post_rst",  C_ADD,  5'd7, 5'd9, 5'd13, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
